// File: rtl/serdesphy_pkg.sv
// serdesphy_pkg: shared types and constants for the serdes PHY TX path.
// Holds the serializer state codes, fixed patterns and the PRBS7 step.
package serdesphy_pkg;

    localparam int WORD_W_DEF = 16;

    localparam logic [15:0] TRAIN_PATTERN = 16'hAAAA;
    localparam logic [15:0] IDLE_WORD     = 16'h55AA;
    localparam logic [6:0]  PRBS7_SEED    = 7'h7F;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_TRAIN = 2'd1,
        ST_DATA  = 2'd2,
        ST_PRBS  = 2'd3
    } tx_state_e;

    // One step of x^7 + x^6 + 1, MSB is the bit that goes out next.
    function automatic logic [6:0] prbs7_step(input logic [6:0] s);
        return {s[5:0], s[6] ^ s[5]};
    endfunction

endpackage

// File: rtl/serdesphy_prbs7_gen.sv
// serdesphy_prbs7_gen: PRBS7 (x^7+x^6+1) state register.
// load reseeds to PRBS7_SEED and wins over advance.
module serdesphy_prbs7_gen
    import serdesphy_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       advance,
    output logic [6:0] state
);

    logic [6:0] state_q;
    logic [6:0] state_d;

    // Next LFSR value: reseed, step, or hold.
    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = PRBS7_SEED;
        end else if (advance) begin
            state_d = prbs7_step(state_q);
        end
    end

    // LFSR register, seeded on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= PRBS7_SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/serdesphy_ana_tx_serializer.sv
// serdesphy_ana_tx_serializer: training / data / PRBS7 serializer.
// A word-boundary driven FSM feeds one registered serial bit, MSB first.
module serdesphy_ana_tx_serializer
    import serdesphy_pkg::*;
#(
    parameter int WORD_W      = WORD_W_DEF,
    parameter int TRAIN_WORDS = 8
) (
    input  logic              clk_240m_tx,
    input  logic              rst,
    input  logic              enable,
    input  logic              prbs_en,
    input  logic              train_req,
    input  logic [WORD_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic              underflow_clr,
    output logic              serial_data,
    output logic [1:0]        tx_state,
    output logic              underflow
);

    localparam int CNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int TC_W  = (TRAIN_WORDS > 1) ? $clog2(TRAIN_WORDS) : 1;

    localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(WORD_W - 1);
    localparam logic [TC_W-1:0]   LAST_WORD = TC_W'(TRAIN_WORDS - 1);
    localparam logic [WORD_W-1:0] TRAIN_W   = WORD_W'(TRAIN_PATTERN);
    localparam logic [WORD_W-1:0] IDLE_W    = WORD_W'(IDLE_WORD);

    tx_state_e         state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [TC_W-1:0]   train_cnt_q, train_cnt_d;
    logic              train_pend_q, train_pend_d;
    logic              underflow_q, underflow_d;
    logic              serial_q, serial_d;

    logic              boundary;
    logic              req_now;
    logic              ready_c;
    logic              uf_set;

    logic [6:0]        lfsr;
    logic [6:0]        lfsr_nxt;
    logic              lfsr_load;
    logic              lfsr_adv;
    logic [5:0]        lfsr_unused;

    assign boundary = (state_q != ST_OFF) && (bit_cnt_q == LAST_BIT);
    assign req_now  = train_pend_q | train_req;

    // Next state, bit/word counters and shift register contents.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q << 1;
        train_cnt_d  = train_cnt_q;
        train_pend_d = train_pend_q;
        ready_c      = 1'b0;
        uf_set       = 1'b0;

        if (!enable) begin
            state_d      = ST_OFF;
            bit_cnt_d    = '0;
            shreg_d      = '0;
            train_cnt_d  = '0;
            train_pend_d = 1'b0;
        end else if (state_q == ST_OFF) begin
            state_d      = ST_TRAIN;
            bit_cnt_d    = '0;
            shreg_d      = TRAIN_W;
            train_cnt_d  = '0;
            train_pend_d = 1'b0;
        end else begin
            bit_cnt_d    = boundary ? '0 : bit_cnt_q + CNT_W'(1);
            train_pend_d = boundary ? 1'b0 : req_now;
            if (boundary) begin
                if (req_now) begin
                    state_d     = ST_TRAIN;
                    train_cnt_d = '0;
                end else begin
                    unique case (state_q)
                        ST_TRAIN: begin
                            if (train_cnt_q == LAST_WORD) begin
                                state_d = prbs_en ? ST_PRBS : ST_DATA;
                            end else begin
                                train_cnt_d = train_cnt_q + TC_W'(1);
                            end
                        end
                        ST_DATA: begin
                            if (prbs_en) state_d = ST_PRBS;
                        end
                        ST_PRBS: begin
                            if (!prbs_en) state_d = ST_DATA;
                        end
                        default: ;
                    endcase
                end

                if (state_d == ST_TRAIN) begin
                    shreg_d = TRAIN_W;
                end else if (state_d == ST_DATA) begin
                    ready_c = 1'b1;
                    uf_set  = !tx_valid;
                    shreg_d = tx_valid ? tx_data : IDLE_W;
                end
            end
        end
    end

    assign lfsr_load = enable && (state_d == ST_PRBS)
                     && (state_q != ST_PRBS);
    assign lfsr_adv  = (state_q == ST_PRBS);

    // Mirror of the generator's next state so serial_data stays a flop.
    assign lfsr_nxt    = lfsr_load ? PRBS7_SEED
                       : (lfsr_adv ? prbs7_step(lfsr) : lfsr);
    assign lfsr_unused = lfsr_nxt[5:0];

    assign serial_d    = (state_d == ST_PRBS) ? lfsr_nxt[6]
                                              : shreg_d[WORD_W-1];
    assign underflow_d = uf_set | (underflow_q & ~underflow_clr);

    serdesphy_prbs7_gen u_prbs (
        .clk     (clk_240m_tx),
        .rst     (rst),
        .load    (lfsr_load),
        .advance (lfsr_adv),
        .state   (lfsr)
    );

    // State and datapath registers; reset aborts any word in flight.
    always_ff @(posedge clk_240m_tx) begin
        if (rst) begin
            state_q      <= ST_OFF;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            train_cnt_q  <= '0;
            train_pend_q <= 1'b0;
            underflow_q  <= 1'b0;
            serial_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            train_cnt_q  <= train_cnt_d;
            train_pend_q <= train_pend_d;
            underflow_q  <= underflow_d;
            serial_q     <= serial_d;
        end
    end

    assign tx_ready    = ready_c && !rst;
    assign serial_data = serial_q;
    assign tx_state    = state_q;
    assign underflow   = underflow_q;

endmodule

// File: tb/tb_serdesphy_ana_tx_serializer.sv
// tb_serdesphy_ana_tx_serializer: scoreboard bench for the TX serializer.
// Expected words are queued when driven and compared as they shift out.
module tb_serdesphy_ana_tx_serializer;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        prbs_en;
    logic        train_req;
    logic [15:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        underflow_clr;
    logic        serial_data;
    logic [1:0]  tx_state;
    logic        underflow;

    int n_chk  = 0;
    int n_fail = 0;

    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    serdesphy_ana_tx_serializer #(
        .WORD_W      (16),
        .TRAIN_WORDS (8)
    ) dut (
        .clk_240m_tx   (clk),
        .rst           (rst),
        .enable        (enable),
        .prbs_en       (prbs_en),
        .train_req     (train_req),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .underflow_clr (underflow_clr),
        .serial_data   (serial_data),
        .tx_state      (tx_state),
        .underflow     (underflow)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_chk(input string tag, input logic [15:0] obs,
                           input int n);
        logic [15:0] e;
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 1, 0);
        end else begin
            e = exp_q.pop_front();
            chk(tag, {16'h0, obs}, {16'h0, e >> (16 - n)});
        end
    endtask

    // One full word: collect 16 bits, set boundary inputs on bit 0.
    task automatic run_word(input string tag, input logic [1:0] st,
                            input logic rdy, input logic vld,
                            input logic [15:0] dat, input logic clr,
                            input logic uf, input logic prbs,
                            input logic treq);
        logic [15:0] obs;
        logic        rdy_seen;
        int          bad_st;
        int          bad_rdy;
        obs      = '0;
        rdy_seen = 1'b0;
        bad_st   = 0;
        bad_rdy  = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            obs = {obs[14:0], serial_data};
            if (tx_state !== st) bad_st++;
            if (i == 0) begin
                chk({tag, "_uf"}, {31'h0, underflow}, {31'h0, uf});
                underflow_clr = 1'b0;
                tx_valid      = vld;
                tx_data       = dat;
                prbs_en       = prbs;
                train_req     = treq;
            end
            if (i == 1) train_req = 1'b0;
            if (i == 15) underflow_clr = clr;
            #1;
            if (i < 15 && tx_ready !== 1'b0) bad_rdy++;
            if (i == 15) rdy_seen = tx_ready;
        end
        chk({tag, "_state"}, bad_st, 0);
        chk({tag, "_rdy_mid"}, bad_rdy, 0);
        chk({tag, "_rdy_bnd"}, {31'h0, rdy_seen}, {31'h0, rdy});
        pop_chk({tag, "_word"}, obs, 16);
        if (rdy) exp_q.push_back(vld ? dat : 16'h55AA);
    endtask

    // First n bits of a word, compared with the top n expected bits.
    task automatic run_part(input string tag, input int n);
        logic [15:0] obs;
        obs = '0;
        for (int i = 0; i < n; i++) begin
            step();
            obs = {obs[14:0], serial_data};
        end
        pop_chk(tag, obs, n);
    endtask

    initial begin
        logic [6:0]   r;
        logic [255:0] bits;
        int           bad_seq;
        int           bad_rdy;
        int           bad_st;
        int           bad_per;

        rst           = 1'b1;
        enable        = 1'b0;
        prbs_en       = 1'b0;
        train_req     = 1'b0;
        tx_data       = '0;
        tx_valid      = 1'b0;
        underflow_clr = 1'b0;

        repeat (3) step();
        chk("rst_state", {30'h0, tx_state}, 0);
        chk("rst_serial", {31'h0, serial_data}, 0);
        chk("rst_uf", {31'h0, underflow}, 0);
        chk("rst_ready", {31'h0, tx_ready}, 0);

        // Enable: 8 training words, then the first data word accepted.
        rst    = 1'b0;
        enable = 1'b1;
        repeat (8) exp_q.push_back(16'hAAAA);
        for (int w = 0; w < 8; w++) begin
            run_word($sformatf("train%0d", w), 2'd1, w == 7, 1'b1,
                     16'h8001, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // Back-to-back data, then underflow with a colliding clear.
        run_word("d8001", 2'd2, 1'b1, 1'b1, 16'hFFFF,
                 1'b0, 1'b0, 1'b0, 1'b0);
        run_word("dFFFF", 2'd2, 1'b1, 1'b0, 16'h0000,
                 1'b0, 1'b0, 1'b0, 1'b0);
        run_word("idle0", 2'd2, 1'b1, 1'b0, 16'h0000,
                 1'b1, 1'b1, 1'b0, 1'b0);
        run_word("idle1", 2'd2, 1'b1, 1'b1, 16'h1234,
                 1'b1, 1'b1, 1'b0, 1'b0);
        run_word("d1234", 2'd2, 1'b0, 1'b1, 16'h0000,
                 1'b0, 1'b0, 1'b1, 1'b0);

        // PRBS7 run against a reference LFSR, then back to data.
        r       = 7'h7F;
        bits    = '0;
        bad_seq = 0;
        bad_rdy = 0;
        bad_st  = 0;
        for (int k = 0; k < 256; k++) begin
            step();
            bits[k] = serial_data;
            if (serial_data !== r[6]) bad_seq++;
            r = {r[5:0], r[6] ^ r[5]};
            if (tx_state !== 2'd3) bad_st++;
            if (k == 249) begin
                prbs_en  = 1'b0;
                tx_valid = 1'b1;
                tx_data  = 16'hF00F;
            end
            #1;
            if (k < 255 && tx_ready !== 1'b0) bad_rdy++;
            if (k == 255) begin
                chk("prbs_exit_rdy", {31'h0, tx_ready}, 1);
                exp_q.push_back(16'hF00F);
            end
        end
        bad_per = 0;
        for (int i = 0; i < 129; i++) begin
            if (bits[i] !== bits[i+127]) bad_per++;
        end
        chk("prbs_first7", {25'h0, bits[6:0]}, 32'h7F);
        chk("prbs_seq", bad_seq, 0);
        chk("prbs_period", bad_per, 0);
        chk("prbs_state", bad_st, 0);
        chk("prbs_rdy", bad_rdy, 0);

        // train_req in DATA, then enable dropped at bit 5 of word 2.
        repeat (3) exp_q.push_back(16'hAAAA);
        run_word("dF00F", 2'd2, 1'b0, 1'b1, 16'h0F0F,
                 1'b0, 1'b0, 1'b0, 1'b1);
        run_word("rtrain0", 2'd1, 1'b0, 1'b0, 16'h0000,
                 1'b0, 1'b0, 1'b0, 1'b0);
        run_word("rtrain1", 2'd1, 1'b0, 1'b0, 16'h0000,
                 1'b0, 1'b0, 1'b0, 1'b0);
        run_part("rtrain2_part", 6);
        enable = 1'b0;
        step();
        chk("off_state", {30'h0, tx_state}, 0);
        chk("off_serial", {31'h0, serial_data}, 0);
        #1;
        chk("off_ready", {31'h0, tx_ready}, 0);

        // Re-enable: count restarts, and a train_req restarts it again.
        enable = 1'b1;
        repeat (12) exp_q.push_back(16'hAAAA);
        for (int w = 0; w < 4; w++) begin
            run_word($sformatf("en_train%0d", w), 2'd1, 1'b0, 1'b0,
                     16'h0000, 1'b0, 1'b0, 1'b0, w == 3);
        end
        for (int w = 0; w < 8; w++) begin
            run_word($sformatf("rq_train%0d", w), 2'd1, w == 7, 1'b1,
                     16'hC3A5, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        run_word("dC3A5", 2'd2, 1'b1, 1'b0, 16'h0000,
                 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset at bit 9 of the idle word in flight.
        run_part("idle_part", 10);
        chk("uf_pre_rst", {31'h0, underflow}, 1);
        rst = 1'b1;
        step();
        chk("mid_rst_state", {30'h0, tx_state}, 0);
        chk("mid_rst_serial", {31'h0, serial_data}, 0);
        chk("mid_rst_uf", {31'h0, underflow}, 0);
        #1;
        chk("mid_rst_ready", {31'h0, tx_ready}, 0);
        rst = 1'b0;
        step();
        chk("post_rst_state", {30'h0, tx_state}, 1);
        chk("post_rst_serial", {31'h0, serial_data}, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
